// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants, status record and helpers for the single-clock FIFO.
package sync_fifo_ctrl_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 9;

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
    logic valid;
  } fifo_status_t;

  localparam fifo_status_t FIFO_STATUS_RST = '{
    full:   1'b0,
    afull:  1'b0,
    empty:  1'b1,
    aempty: 1'b1,
    valid:  1'b0
  };

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module sync_fifo_ram
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset; the array contents are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy, registered status flags, sticky
// error flags and an optional first-word-fall-through output stage.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned AFULL_TH  = 500,
  parameter int unsigned AEMPTY_TH = 12,
  parameter int unsigned FWFT      = FIFO_MODE_STD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  output logic              w_afull,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_empty,
  output logic              r_aempty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned     CW        = ADDR_W + 1;
  localparam int unsigned     DEPTH     = fifo_depth(ADDR_W);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]   AFULL_C   = CW'(AFULL_TH);
  localparam logic [CW-1:0]   AEMPTY_C  = CW'(AEMPTY_TH);
  localparam bit              IS_FWFT   = (FWFT == FIFO_MODE_FWFT);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [CW-1:0]     cnt_q, cnt_d, mem_words;
  logic              wr_acc, rd_acc, ram_rd, move, out_vld_d;
  logic              ram_vld, out_vld;
  logic [DATA_W-1:0] ram_dout, out_q;
  fifo_status_t      stat_q, stat_d;
  logic              ovf_q, unf_q;

  sync_fifo_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (w_data),
    .re    (ram_rd),
    .raddr (rptr),
    .rdata (ram_dout)
  );

  // FWFT prefetch is two stages: the RAM read register, then out_q. A word
  // moves forward whenever the next stage is empty or being popped, so a
  // held r_en drains one word per cycle. count covers both stages.
  always_comb begin
    wr_acc    = w_en & ~stat_q.full;
    rd_acc    = r_en & ~stat_q.empty;
    mem_words = cnt_q - CW'(ram_vld) - CW'(out_vld);
    move      = ram_vld & (~out_vld | rd_acc);
    out_vld_d = move | (out_vld & ~rd_acc);

    if (IS_FWFT) begin
      ram_rd = (~ram_vld | move) & (mem_words != '0);
    end else begin
      ram_rd = rd_acc;
    end

    cnt_d = cnt_q;
    if (wr_acc && !rd_acc) begin
      cnt_d = cnt_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_d = cnt_q - CW'(1);
    end

    stat_d.full   = (cnt_d == DEPTH_C);
    stat_d.afull  = (cnt_d >= AFULL_C);
    stat_d.aempty = (cnt_d <= AEMPTY_C);
    if (IS_FWFT) begin
      stat_d.empty = ~out_vld_d;
      stat_d.valid = out_vld_d;
    end else begin
      stat_d.empty = (cnt_d == '0);
      stat_d.valid = rd_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt_q   <= '0;
      stat_q  <= FIFO_STATUS_RST;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ram_vld <= 1'b0;
      out_vld <= 1'b0;
      out_q   <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (ram_rd) begin
        rptr <= rptr + ADDR_W'(1);
      end
      cnt_q  <= cnt_d;
      stat_q <= stat_d;
      ovf_q  <= (w_en & stat_q.full)  | (ovf_q & ~clr_err);
      unf_q  <= (r_en & stat_q.empty) | (unf_q & ~clr_err);
      if (IS_FWFT) begin
        ram_vld <= ram_rd | (ram_vld & ~move);
        out_vld <= out_vld_d;
        if (move) begin
          out_q <= ram_dout;
        end
      end
    end
  end

  assign w_full    = stat_q.full;
  assign w_afull   = stat_q.afull;
  assign r_empty   = stat_q.empty;
  assign r_aempty  = stat_q.aempty;
  assign r_valid   = stat_q.valid;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign r_data    = IS_FWFT ? out_q : ram_dout;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl in standard and FWFT read modes.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_rst, s_w_en, s_r_en, s_clr;
  logic [7:0] s_w_data, s_r_data;
  logic       s_w_full, s_w_afull, s_r_valid, s_r_empty, s_r_aempty, s_ovf, s_unf;
  logic [9:0] s_count;

  logic       f_rst, f_w_en, f_r_en, f_clr;
  logic [7:0] f_w_data, f_r_data;
  logic       f_w_full, f_w_afull, f_r_valid, f_r_empty, f_r_aempty, f_ovf, f_unf;
  logic [9:0] f_count;

  int checks = 0;
  int fails  = 0;

  sync_fifo_ctrl #(
    .DATA_W(8), .ADDR_W(9), .AFULL_TH(500), .AEMPTY_TH(12), .FWFT(0)
  ) dut_std (
    .clk(clk), .rst(s_rst), .w_en(s_w_en), .w_data(s_w_data),
    .w_full(s_w_full), .w_afull(s_w_afull), .r_en(s_r_en), .r_data(s_r_data),
    .r_valid(s_r_valid), .r_empty(s_r_empty), .r_aempty(s_r_aempty),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf), .clr_err(s_clr)
  );

  sync_fifo_ctrl #(
    .DATA_W(8), .ADDR_W(9), .AFULL_TH(500), .AEMPTY_TH(12), .FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst(f_rst), .w_en(f_w_en), .w_data(f_w_data),
    .w_full(f_w_full), .w_afull(f_w_afull), .r_en(f_r_en), .r_data(f_r_data),
    .r_valid(f_r_valid), .r_empty(f_r_empty), .r_aempty(f_r_aempty),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    s_rst = 1'b1; s_w_en = 1'b0; s_r_en = 1'b0; s_clr = 1'b0; s_w_data = '0;
    f_rst = 1'b1; f_w_en = 1'b0; f_r_en = 1'b0; f_clr = 1'b0; f_w_data = '0;
    repeat (2) tick();

    check("rst_count",    32'(s_count),    0);
    check("rst_empty",    32'(s_r_empty),  1);
    check("rst_aempty",   32'(s_r_aempty), 1);
    check("rst_full",     32'(s_w_full),   0);
    check("rst_afull",    32'(s_w_afull),  0);
    check("rst_valid",    32'(s_r_valid),  0);
    check("rst_rdata",    32'(s_r_data),   0);
    check("rst_overflow", 32'(s_ovf),      0);
    check("rst_underflow",32'(s_unf),      0);
    s_rst = 1'b0;
    f_rst = 1'b0;
    tick();

    // Fill 512 words: 0x00..0xFF twice
    for (int i = 0; i < 512; i++) begin
      s_w_en = 1'b1; s_w_data = 8'(i);
      tick();
      check("fill_afull", 32'(s_w_afull), (i + 1 >= 500) ? 1 : 0);
      check("fill_full",  32'(s_w_full),  (i + 1 == 512) ? 1 : 0);
    end
    s_w_en = 1'b0;
    check("full_count",  32'(s_count),    512);
    check("full_empty",  32'(s_r_empty),  0);
    check("full_aempty", 32'(s_r_aempty), 0);

    // Overflow, set-wins-over-clear, then clear
    s_w_en = 1'b1; s_w_data = 8'hAA;
    tick();
    check("ovf_set",   32'(s_ovf),   1);
    check("ovf_count", 32'(s_count), 512);
    s_clr = 1'b1;
    tick();
    check("ovf_set_wins", 32'(s_ovf), 1);
    s_w_en = 1'b0;
    tick();
    s_clr = 1'b0;
    check("ovf_clear", 32'(s_ovf), 0);

    // Drain 512 with one-cycle latency, 0xAA must never appear
    for (int i = 0; i < 512; i++) begin
      s_r_en = 1'b1;
      tick();
      check("drain_valid",  32'(s_r_valid),  1);
      check("drain_data",   32'(s_r_data),   i % 256);
      check("drain_aempty", 32'(s_r_aempty), (511 - i <= 12) ? 1 : 0);
    end
    s_r_en = 1'b0;
    check("drain_empty", 32'(s_r_empty), 1);
    check("drain_count", 32'(s_count),   0);
    check("drain_full",  32'(s_w_full),  0);
    tick();
    check("idle_valid", 32'(s_r_valid), 0);
    check("idle_hold",  32'(s_r_data),  'hFF);

    // Underflow and simultaneous access while empty
    s_r_en = 1'b1;
    tick();
    s_r_en = 1'b0;
    check("unf_set",   32'(s_unf),     1);
    check("unf_valid", 32'(s_r_valid), 0);
    check("unf_count", 32'(s_count),   0);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check("unf_clear", 32'(s_unf), 0);
    s_w_en = 1'b1; s_r_en = 1'b1; s_w_data = 8'h5A;
    tick();
    s_w_en = 1'b0; s_r_en = 1'b0;
    check("emp_rw_count", 32'(s_count),   1);
    check("emp_rw_unf",   32'(s_unf),     1);
    check("emp_rw_valid", 32'(s_r_valid), 0);
    check("emp_rw_empty", 32'(s_r_empty), 0);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    s_r_en = 1'b1;
    tick();
    s_r_en = 1'b0;
    check("emp_rw_data", 32'(s_r_data), 'h5A);
    check("emp_rw_drained", 32'(s_count), 0);

    // Hold occupancy at 3 with concurrent read/write across pointer wrap
    for (int k = 0; k < 3; k++) begin
      s_w_en = 1'b1; s_w_data = 8'(k);
      tick();
    end
    for (int k = 3; k < 1003; k++) begin
      s_w_en = 1'b1; s_r_en = 1'b1; s_w_data = 8'(k);
      tick();
      check("wrap_count", 32'(s_count),   3);
      check("wrap_valid", 32'(s_r_valid), 1);
      check("wrap_data",  32'(s_r_data),  (k - 3) % 256);
    end
    s_w_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("wrap_tail", 32'(s_r_data), (1000 + j) % 256);
    end
    s_r_en = 1'b0;
    check("wrap_empty", 32'(s_r_empty), 1);

    // Full with simultaneous read and write
    for (int i = 0; i < 512; i++) begin
      s_w_en = 1'b1; s_w_data = 8'(i + 'h40);
      tick();
    end
    s_w_en = 1'b1; s_r_en = 1'b1; s_w_data = 8'hBB;
    tick();
    s_w_en = 1'b0; s_r_en = 1'b0;
    check("full_rw_ovf",   32'(s_ovf),     1);
    check("full_rw_valid", 32'(s_r_valid), 1);
    check("full_rw_data",  32'(s_r_data),  'h40);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;

    // Drain down to 37 words, then reset in the middle of a burst
    n = 0;
    while (s_count != 10'd37 && n < 600) begin
      s_r_en = 1'b1;
      tick();
      n++;
    end
    s_r_en = 1'b0;
    check("to37_bound", (n < 600) ? 1 : 0, 1);
    s_w_en = 1'b1; s_r_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_w_data = 8'(i + 'h70);
      tick();
      check("burst_count", 32'(s_count), 37);
    end
    #3;
    s_rst = 1'b1;
    #1;
    check("arst_count",  32'(s_count),    0);
    check("arst_empty",  32'(s_r_empty),  1);
    check("arst_aempty", 32'(s_r_aempty), 1);
    check("arst_valid",  32'(s_r_valid),  0);
    check("arst_rdata",  32'(s_r_data),   0);
    check("arst_full",   32'(s_w_full),   0);
    tick();
    s_rst = 1'b0; s_w_en = 1'b0; s_r_en = 1'b0;
    tick();
    check("post_rst_empty", 32'(s_r_empty), 1);
    check("post_rst_count", 32'(s_count),   0);

    // FWFT: first word appears two edges after the write edge
    check("fw_rst_empty", 32'(f_r_empty), 1);
    check("fw_rst_valid", 32'(f_r_valid), 0);
    f_w_en = 1'b1; f_w_data = 8'h11;
    tick();
    f_w_en = 1'b0;
    check("fw_e0_count", 32'(f_count),   1);
    check("fw_e0_empty", 32'(f_r_empty), 1);
    tick();
    check("fw_e1_empty", 32'(f_r_empty), 1);
    tick();
    check("fw_e2_empty", 32'(f_r_empty), 0);
    check("fw_e2_valid", 32'(f_r_valid), 1);
    check("fw_e2_data",  32'(f_r_data),  'h11);
    for (int i = 'h12; i <= 'h20; i++) begin
      f_w_en = 1'b1; f_w_data = 8'(i);
      tick();
    end
    f_w_en = 1'b0;
    repeat (2) tick();
    check("fw_count16", 32'(f_count), 16);

    // Stream with r_en held: one word per cycle, no bubble
    for (int j = 0; j < 16; j++) begin
      check("fw_stream_valid", 32'(f_r_valid), 1);
      check("fw_stream_data",  32'(f_r_data),  'h11 + j);
      f_r_en = 1'b1;
      tick();
    end
    f_r_en = 1'b0;
    check("fw_end_empty", 32'(f_r_empty), 1);
    check("fw_end_valid", 32'(f_r_valid), 0);
    check("fw_end_count", 32'(f_count),   0);
    check("fw_end_unf",   32'(f_unf),     0);
    f_r_en = 1'b1;
    tick();
    f_r_en = 1'b0;
    check("fw_unf_set", 32'(f_unf), 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised FIFO: internal dual-port storage, write/read pointers, occupancy counter and status flags in one block.
- Used wherever a producer and consumer share one clock.
- Adds programmable almost-full/almost-empty thresholds, an optional first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 9, pointer width; DEPTH = 2**ADDR_W words (512).
- AFULL_TH, 500, w_afull asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 12, r_aempty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk       input   1         single system clock; all logic on rising edge
- rst       input   1         asynchronous, active-high reset
- w_en      input   1         write request
- w_data    input   DATA_W    write data
- w_full    output  1         FIFO full; a write this cycle is rejected
- w_afull   output  1         almost full
- r_en      input   1         read request (pop in FWFT mode)
- r_data    output  DATA_W    read data
- r_valid   output  1         r_data valid (standard: 1-cycle pulse; FWFT: = !r_empty)
- r_empty   output  1         no word available to read
- r_aempty  output  1         almost empty
- count     output  ADDR_W+1  words stored, 0..DEPTH
- overflow  output  1         sticky: a write was attempted while w_full
- underflow output  1         sticky: a read was attempted while r_empty
- clr_err   input   1         synchronous clear of overflow/underflow

Behaviour:
- Reset (async assert, sync release): pointers=0, count=0, w_full=0, w_afull=0, r_empty=1, r_aempty=1, r_valid=0, r_data=0, overflow=0, underflow=0. Memory contents undefined.
- Accepted write: wr_acc = w_en & !w_full. Data goes to mem[wptr]; wptr increments modulo DEPTH.
- Accepted read: rd_acc = r_en & !r_empty.
- All status outputs are registered and flags are evaluated on the post-edge count:
  - w_full = (count == DEPTH)
  - w_afull = (count >= AFULL_TH)
  - r_aempty = (count <= AEMPTY_TH)
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Simultaneous w_en & r_en:
  - When full: read accepted, write rejected, overflow set.
  - When empty: write accepted, read rejected, underflow set.
  - Otherwise both accepted, count unchanged.
- Standard mode (FWFT=0):
  - r_empty = (count == 0).
  - On rd_acc, mem[rptr] is registered into r_data and r_valid pulses high the next cycle.
  - Read latency = 1 clk. r_data holds its value when there is no read.
- FWFT mode (FWFT=1):
  - A 1-entry output register prefetches automatically.
  - r_data shows the head word whenever r_empty=0.
  - r_en pops the head; the next word is shown the following cycle with no bubble while count > 1.
  - A write into an empty FIFO makes r_empty deassert 2 cycles after the write edge (mem write, then prefetch).
  - count includes the prefetched word.
  - r_valid = !r_empty.
- Wrap-around: pointers roll from DEPTH-1 to 0 transparently; full/empty come from count, never from pointer compare.
- Error flags:
  - overflow sets on w_en & w_full; underflow sets on r_en & r_empty.
  - Both hold until clr_err or rst. If set and clr_err occur in the same cycle, set wins.
  - A rejected access never changes pointers, count or memory.
- Reset mid-operation: all contents are discarded immediately; FIFO reads empty from the first edge after release.

Decomposition:
- Shared package holds:
  - fifo_depth function (2**ADDR_W)
  - mode constants FIFO_MODE_STD=0, FIFO_MODE_FWFT=1
  - default DATA_W/ADDR_W
- One sub-module, sync_fifo_ram: simple dual-port array with one write port and one registered read port.
- Pointers, count, flags and the FWFT prefetch stage stay in sync_fifo_ctrl.

Test Plan:
- Fill/drain, FWFT=0: write 0x00..0xFF then 0x00..0xFF (512 words).
  - Then w_full=1, count=512, w_afull high from count 500.
  - Read 512: data returns in order at 1-cycle latency, r_empty=1 after last pop, r_aempty high from count 12.
- Overflow: at full, w_en=1 with data 0xAA → overflow=1, count stays 512, 0xAA never read.
  - clr_err → overflow=0 next cycle.
- Underflow and simultaneous ops:
  - Empty, r_en=1 → underflow=1, r_valid stays 0.
  - Empty, w_en & r_en with 0x5A → count=1, underflow=1.
  - Full, w_en & r_en → count stays 512, overflow=1.
- Wrap: 1000 cycles of continuous w_en & r_en at count=3 with an incrementing pattern → count fixed at 3, no data corruption across pointer wrap.
- FWFT=1:
  - Write 0x11 into empty → r_empty=0 and r_data=0x11 two edges later.
  - Stream 0x11..0x20 with r_en held high → one word per cycle, no bubble, r_empty=1 after 0x20.
- Async reset mid-burst: assert rst between edges at count=37 → all outputs take reset values immediately, count=0, r_empty=1.
